// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard unit:
//               forwarding selects, result-source encoding and the
//               data-memory wait FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  // Execute-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // resultsrc encoding that marks a load in execute
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Data-memory wait state machine
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/forward_sel.sv
// ============================================================================
// Module      : forward_sel
// Description : Single-operand forwarding select. Memory-stage result wins
//               over writeback; register x0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_rs,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_mem,
  input  logic                      i_regwrite_mem,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_wb,
  input  logic                      i_regwrite_wb,
  output fwd_sel_t                  o_sel
);

  // Prioritised compare: memory stage first, then writeback, else register file
  always_comb begin
    o_sel = FWD_RF;
    if (i_regwrite_mem && (i_rd_mem != '0) && (i_rd_mem == i_rs)) begin
      o_sel = FWD_MEM;
    end else if (i_regwrite_wb && (i_rd_wb != '0) && (i_rd_wb == i_rs)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard controller for the five-stage core. Produces
//               stall, flush and forwarding selects, and runs a data-memory
//               wait FSM that freezes the pipe during a pending access and
//               raises a sticky timeout flag.
//               Optional feature macro: HAZARD_PERF_EN adds saturating
//               stall_cycles / flush_events performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_WAIT       = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1e,
  input  logic [REG_ADDR_WIDTH-1:0] rs2e,
  input  logic [REG_ADDR_WIDTH-1:0] rde,
  input  logic [1:0]                resultsrce,
  input  logic                      pcsrce,
  input  logic [REG_ADDR_WIDTH-1:0] rdm,
  input  logic                      regwritem,
  input  logic                      memreqm,
  input  logic                      mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] rdw,
  input  logic                      regwritew,
  output logic                      stallf,
  output logic                      stalld,
  output logic                      stalle,
  output logic                      stallm,
  output logic                      flushd,
  output logic                      flushe,
  output logic                      flushw,
  output logic [1:0]                forwardae,
  output logic [1:0]                forwardbe,
  output logic                      mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_events
`endif
);

  // Wait counter must be able to hold MAX_WAIT itself
  localparam int              CW    = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   C_MAX = CW'(MAX_WAIT);
  localparam logic [CW-1:0]   C_ONE = CW'(1);

  // Elaboration-time parameter sanity
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("hazard_unit: MAX_WAIT must be >= 1");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("hazard_unit: CNT_WIDTH must be >= 1");
  end

  fwd_sel_t   w_fwd_a;
  fwd_sel_t   w_fwd_b;
  logic       w_memstall;
  logic       w_lwstall;
  mem_state_t r_state;
  mem_state_t w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic       r_timeout;

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .i_rs           (rs1e),
    .i_rd_mem       (rdm),
    .i_regwrite_mem (regwritem),
    .i_rd_wb        (rdw),
    .i_regwrite_wb  (regwritew),
    .o_sel          (w_fwd_a)
  );

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .i_rs           (rs2e),
    .i_rd_mem       (rdm),
    .i_regwrite_mem (regwritem),
    .i_rd_wb        (rdw),
    .i_regwrite_wb  (regwritew),
    .o_sel          (w_fwd_b)
  );

  assign w_memstall = memreqm && !mem_ready;
  assign w_lwstall  = (resultsrce == RESULT_LOAD) && (rde != '0) &&
                      ((rde == rs1d) || (rde == rs2d));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: enter wait on a stalled access, leave once it resolves
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:      if (w_memstall) w_state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ready || !memreqm) w_state_next = RUN;
      default:  w_state_next = RUN;
    endcase
  end

  // Hazard outputs: reset forces flushes, a memory stall freezes everything
  // and defers redirects / load-use handling until the pipe advances
  always_comb begin
    stallf    = 1'b0;
    stalld    = 1'b0;
    stalle    = 1'b0;
    stallm    = 1'b0;
    flushd    = 1'b0;
    flushe    = 1'b0;
    flushw    = 1'b0;
    forwardae = FWD_RF;
    forwardbe = FWD_RF;
    if (rst) begin
      flushd = 1'b1;
      flushe = 1'b1;
      flushw = 1'b1;
    end else begin
      forwardae = w_fwd_a;
      forwardbe = w_fwd_b;
      if (w_memstall) begin
        stallf = 1'b1;
        stalld = 1'b1;
        stalle = 1'b1;
        stallm = 1'b1;
        flushw = 1'b1;
      end else begin
        stallf = w_lwstall;
        stalld = w_lwstall;
        flushd = pcsrce;
        flushe = pcsrce || w_lwstall;
      end
    end
  end

  // Wait counter next value: loads 1 on entry, saturates at MAX_WAIT
  always_comb begin
    w_cnt_next = '0;
    if (w_memstall) begin
      if (r_state == RUN) begin
        w_cnt_next = C_ONE;
      end else if (r_cnt == C_MAX) begin
        w_cnt_next = r_cnt;
      end else begin
        w_cnt_next = r_cnt + C_ONE;
      end
    end
  end

  // Wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_memstall && (w_cnt_next == C_MAX)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign mem_timeout = r_timeout;

`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_flush_events;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (stallf && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (pcsrce && !w_memstall && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + 1'b1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit. A driver issues one
//               stimulus vector per cycle and queues the expected outputs
//               from a reference model; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] resultsrce;
    logic       pcsrce;
    logic [4:0] rdm;
    logic       regwritem, memreqm, mem_ready;
    logic [4:0] rdw;
    logic       regwritew;
  } stim_t;

  typedef struct packed {
    logic [3:0] stalls;   // {f,d,e,m}
    logic [2:0] flushes;  // {d,e,w}
    logic [1:0] fa, fb;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0] resultsrce;
  logic pcsrce, regwritem, memreqm, mem_ready, regwritew;
  logic stallf, stalld, stalle, stallm, flushd, flushe, flushw, mem_timeout;
  logic [1:0] forwardae, forwardbe;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // model state: length of the current continuous memory stall and sticky flag
  int   m_run = 0;
  bit   m_to  = 1'b0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_WIDTH(5), .MAX_WAIT(MAX_WAIT), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
    .resultsrce(resultsrce), .pcsrce(pcsrce),
    .rdm(rdm), .regwritem(regwritem), .memreqm(memreqm), .mem_ready(mem_ready),
    .rdw(rdw), .regwritew(regwritew),
    .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm),
    .flushd(flushd), .flushe(flushe), .flushw(flushw),
    .forwardae(forwardae), .forwardbe(forwardbe), .mem_timeout(mem_timeout)
  );

  function automatic logic [1:0] fwd_ref(stim_t s, logic [4:0] rs);
    if (s.regwritem && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.regwritew && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model(stim_t s, bit to);
    exp_t e;
    bit ms, lw;
    ms = s.memreqm && !s.mem_ready;
    lw = (s.resultsrce == 2'b01) && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
    e.to = to;
    if (s.rst) begin
      e.stalls = 4'b0000; e.flushes = 3'b111; e.fa = 2'b00; e.fb = 2'b00;
    end else begin
      e.fa = fwd_ref(s, s.rs1e);
      e.fb = fwd_ref(s, s.rs2e);
      if (ms) begin
        e.stalls = 4'b1111; e.flushes = 3'b001;
      end else begin
        e.stalls  = {lw, lw, 2'b00};
        e.flushes = {s.pcsrce, s.pcsrce | lw, 1'b0};
      end
    end
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Apply one cycle of stimulus, queue its expectation, advance the model
  task automatic step(input stim_t s);
    @(posedge clk); #1;
    rst = s.rst; rs1d = s.rs1d; rs2d = s.rs2d; rs1e = s.rs1e; rs2e = s.rs2e;
    rde = s.rde; resultsrce = s.resultsrce; pcsrce = s.pcsrce; rdm = s.rdm;
    regwritem = s.regwritem; memreqm = s.memreqm; mem_ready = s.mem_ready;
    rdw = s.rdw; regwritew = s.regwritew;
    sb.push_back(model(s, m_to));
    if (s.rst) begin
      m_run = 0; m_to = 1'b0;
    end else if (s.memreqm && !s.mem_ready) begin
      m_run++;
      if (m_run >= MAX_WAIT) m_to = 1'b1;
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stalls",      {stallf, stalld, stalle, stallm}, e.stalls);
        check("flushes",     {1'b0, flushd, flushe, flushw},   {1'b0, e.flushes});
        check("forwardae",   {2'b00, forwardae},               {2'b00, e.fa});
        check("forwardbe",   {2'b00, forwardbe},               {2'b00, e.fb});
        check("mem_timeout", {3'b000, mem_timeout},            {3'b000, e.to});
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1; rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; resultsrce = 0;
    pcsrce = 0; rdm = 0; regwritem = 0; memreqm = 0; mem_ready = 0; rdw = 0; regwritew = 0;

    // reset
    s = idle(); s.rst = 1'b1; step(s); step(s);
    step(idle());

    // forwarding priority and x0
    s = idle(); s.regwritem = 1; s.rdm = 5; s.rs1e = 5; s.regwritew = 1; s.rdw = 5; step(s);
    s = idle(); s.regwritew = 1; s.rdw = 9; s.rs2e = 9; s.regwritem = 1; s.rdm = 3; step(s);
    s = idle(); s.regwritem = 1; s.rdm = 0; s.rs1e = 0; s.regwritew = 1; step(s);

    // load-use for one cycle, then x0 destination
    s = idle(); s.resultsrce = 2'b01; s.rde = 7; s.rs2d = 7; step(s);
    step(idle());
    s = idle(); s.resultsrce = 2'b01; s.rde = 0; s.rs1d = 0; step(s);

    // redirect, and redirect together with load-use
    s = idle(); s.pcsrce = 1; step(s);
    s = idle(); s.pcsrce = 1; s.resultsrce = 2'b01; s.rde = 4; s.rs1d = 4; step(s);

    // 1-cycle hit, then 4-cycle miss (3 stall cycles)
    s = idle(); s.memreqm = 1; s.mem_ready = 1; step(s);
    s = idle(); s.memreqm = 1;
    repeat (3) step(s);
    s.mem_ready = 1; step(s);
    step(idle());

    // timeout: 6 stall cycles with redirect pending, then release
    s = idle(); s.memreqm = 1; s.pcsrce = 1;
    repeat (6) step(s);
    s.mem_ready = 1; step(s);
    repeat (2) step(idle());

    // reset mid-wait
    s = idle(); s.memreqm = 1; step(s); step(s);
    s.rst = 1; step(s);
    s.rst = 0; step(s);
    s = idle(); s.rst = 1; step(s);
    step(idle());

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s.rst        = ($urandom_range(0, 59) == 0);
      s.rs1d       = 5'($urandom_range(0, 3));
      s.rs2d       = 5'($urandom_range(0, 3));
      s.rs1e       = 5'($urandom_range(0, 3));
      s.rs2e       = 5'($urandom_range(0, 3));
      s.rde        = 5'($urandom_range(0, 3));
      s.resultsrce = 2'($urandom_range(0, 3));
      s.pcsrce     = ($urandom_range(0, 3) == 0);
      s.rdm        = 5'($urandom_range(0, 3));
      s.regwritem  = 1'($urandom_range(0, 1));
      s.memreqm    = 1'($urandom_range(0, 1));
      s.mem_ready  = ($urandom_range(0, 9) < 3);
      s.rdw        = 5'($urandom_range(0, 3));
      s.regwritew  = 1'($urandom_range(0, 1));
      step(s);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage core. It consumes register indices and control bits from the decode/execute, memory and writeback pipeline registers. It produces the stall, flush (`clr`) and forwarding-select signals that drive those registers and the execute-stage operand muxes. It also contains a data-memory wait state machine, which freezes the pipe while a memory access is pending and flags a timeout.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, register index width
- `MAX_WAIT`, 16, memory wait cycles before timeout is flagged (>= 1)
- `CNT_WIDTH`, 32, width of performance counters

Ports:
- `clk` in 1: core clock
- `rst` in 1: synchronous, active-high reset
- `rs1d`, `rs2d` in 5: source indices in decode
- `rs1e`, `rs2e`, `rde` in 5: source and destination indices in execute
- `resultsrce` in 2: result select in execute; `2'b01` = load
- `pcsrce` in 1: branch taken or jump in execute
- `rdm` in 5, `regwritem` in 1: memory-stage destination and write enable
- `memreqm` in 1: memory stage holds a load or store
- `mem_ready` in 1: data memory completes the access this cycle
- `rdw` in 5, `regwritew` in 1: writeback destination and write enable
- `stallf`, `stalld`, `stalle`, `stallm` out 1: hold the PC, IF/ID, ID/EX and EX/MEM registers
- `flushd`, `flushe`, `flushw` out 1: clear IF/ID, ID/EX and MEM/WB (drive `clr`)
- `forwardae`, `forwardbe` out 2: execute operand select
- `mem_timeout` out 1: sticky error flag

## Operation
- **Forwarding, per operand (A uses `rs1e`, B uses `rs2e`).**
  - `2'b10` when `regwritem`, `rdm != 0` and `rdm == rsXe`.
  - Otherwise `2'b01` when `regwritew`, `rdw != 0` and `rdw == rsXe`.
  - Otherwise `2'b00`.
  - The memory stage has priority over writeback.
- **Load-use hazard.** `lwstall = (resultsrce == 2'b01) && rde != 0 && (rde == rs1d || rde == rs2d)`.
- **Memory stall.** `memstall = memreqm && !mem_ready`.
- **Outputs with `memstall = 1` (highest priority).**
  - `stallf = stalld = stalle = stallm = 1`
  - `flushw = 1`
  - `flushd = flushe = 0`
  - A pending redirect or load-use stall is not acted on yet. It stays visible because execute is held, and is serviced on the cycle the pipe advances.
- **Outputs with `memstall = 0`.**
  - `stallf = stalld = lwstall`
  - `stalle = stallm = flushw = 0`
  - `flushd = pcsrce`
  - `flushe = pcsrce || lwstall`
- **FSM, states `RUN` and `MEM_WAIT`.**
  - `RUN` → `MEM_WAIT` when `memstall`; the wait counter loads 1.
  - `MEM_WAIT` stays while `memstall` and increments the counter, saturating at `MAX_WAIT`.
  - `MEM_WAIT` → `RUN` when `mem_ready` or `!memreqm`; the counter clears.
  - `mem_timeout` sets when the counter reaches `MAX_WAIT`. It stays set until `rst`. The stall is not released by a timeout.
- **Reset state.**
  - Registers: state `RUN`, counter 0, `mem_timeout = 0`.
  - Combinational outputs while `rst = 1`: all stalls 0, `flushd = flushe = flushw = 1`, forwards `2'b00`.
  - A reset asserted mid-wait abandons the wait on the next edge.

## Timing
- Stalls, flushes and forwards are combinational from inputs and state, with zero latency. They are valid before the same edge that updates the pipeline registers.
- FSM, counter and `mem_timeout` update on the `posedge clk`.
- With a 1-cycle memory hit (`mem_ready` high with `memreqm`), there is no stall and the FSM stays in `RUN`.
- An N-cycle miss stalls N−1 cycles.
- The timeout flag rises on the edge that completes cycle `MAX_WAIT` of continuous stall.
- Simultaneous `pcsrce` and `lwstall`:
  - `flushd = flushe = 1` and `stalld = 1`.
  - The flush wins on IF/ID because the pipeline registers give `clr` priority.
  - The redirect is taken.

## Configuration
- `HAZARD_PERF_EN` defined adds outputs `stall_cycles` and `flush_events`, both `CNT_WIDTH` wide, saturating, cleared by `rst`.
  - `stall_cycles` increments on each cycle where `stallf = 1`.
  - `flush_events` increments on each cycle where `pcsrce && !memstall`.
- Undefined: the ports and counters are absent.

## Structure
- `hazard_pkg` holds:
  - `fwd_sel_t` (`FWD_RF = 2'b00`, `FWD_WB = 2'b01`, `FWD_MEM = 2'b10`)
  - `RESULT_LOAD = 2'b01`
  - `mem_state_t` (`RUN`, `MEM_WAIT`)
- Sub-module `forward_sel` handles the single-operand compare/priority and is instantiated twice.

## Test plan
- `regwritem = 1`, `rdm = 5`, `rs1e = 5`, `regwritew = 1`, `rdw = 5` → `forwardae = 2'b10`. With `rdm = 0` and `rs1e = 0` → `2'b00`.
- `resultsrce = 01`, `rde = 7`, `rs2d = 7` → `stallf = stalld = flushe = 1`, `flushd = 0`, for exactly one cycle. With `rde = 0` → no stall.
- `pcsrce = 1`, no other hazard → `flushd = flushe = 1`, no stalls.
- `memreqm = 1`, `mem_ready` low 3 cycles then high → `stallf`–`stallm` and `flushw` high 3 cycles. FSM returns to `RUN`. `mem_timeout = 0`.
- `MAX_WAIT = 4`, `mem_ready` held low 6 cycles → `mem_timeout` rises after the 4th stall cycle and stays high until `rst`.
- `pcsrce = 1` during a memory stall → `flushd = flushe = 0` until `mem_ready`, then 1 in that cycle. `rst` mid-wait → state `RUN`, all flushes high.
